// File: rtl/kalman_channel_scheduler.sv
// Time-shares one single-update Kalman core across NUM_CH channels: per-channel x/P/Q/R
// banks, a one-deep measurement buffer per channel, and round-robin issue to the core.
module kalman_channel_scheduler #(
  parameter int unsigned         NUM_CH      = 4,
  parameter int unsigned         STATE_BITS  = 16,
  parameter int unsigned         VAR_BITS    = 64,
  parameter logic [VAR_BITS-1:0] P_INIT      = 64'd1 << 30,
  parameter int unsigned         TIMEOUT_CYC = 255,
  parameter int unsigned         CH_W        = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            z_valid,
  input  logic [NUM_CH*STATE_BITS-1:0] z_in,
  output logic [NUM_CH-1:0]            z_ready,
  input  logic [NUM_CH-1:0]            ch_clear,
  input  logic                         cfg_we,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic [VAR_BITS-1:0]          cfg_q,
  input  logic [VAR_BITS-1:0]          cfg_r,
  output logic                         core_start,
  output logic [STATE_BITS-1:0]        core_x,
  output logic [VAR_BITS-1:0]          core_p,
  output logic [STATE_BITS-1:0]        core_z,
  output logic [VAR_BITS-1:0]          core_q,
  output logic [VAR_BITS-1:0]          core_r,
  input  logic                         core_done,
  input  logic [STATE_BITS-1:0]        core_x_new,
  input  logic [VAR_BITS-1:0]          core_p_new,
  output logic                         out_valid,
  output logic [CH_W-1:0]              out_ch,
  output logic [STATE_BITS-1:0]        out_x,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  state_t                state_q, state_d;
  logic [STATE_BITS-1:0] x_bank_q [NUM_CH];
  logic [STATE_BITS-1:0] x_bank_d [NUM_CH];
  logic [VAR_BITS-1:0]   p_bank_q [NUM_CH];
  logic [VAR_BITS-1:0]   p_bank_d [NUM_CH];
  logic [VAR_BITS-1:0]   q_bank_q [NUM_CH];
  logic [VAR_BITS-1:0]   q_bank_d [NUM_CH];
  logic [VAR_BITS-1:0]   r_bank_q [NUM_CH];
  logic [VAR_BITS-1:0]   r_bank_d [NUM_CH];
  logic [STATE_BITS-1:0] zbuf_q   [NUM_CH];
  logic [STATE_BITS-1:0] zbuf_d   [NUM_CH];
  logic [NUM_CH-1:0]     pend_q, pend_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  discard_q, discard_d;
  logic                  core_start_q, core_start_d;
  logic [STATE_BITS-1:0] core_x_q, core_x_d;
  logic [VAR_BITS-1:0]   core_p_q, core_p_d;
  logic [STATE_BITS-1:0] core_z_q, core_z_d;
  logic [VAR_BITS-1:0]   core_q_q, core_q_d;
  logic [VAR_BITS-1:0]   core_r_q, core_r_d;
  logic                  out_valid_q, out_valid_d;
  logic [CH_W-1:0]       out_ch_q, out_ch_d;
  logic [STATE_BITS-1:0] out_x_q, out_x_d;
  logic                  busy_q, busy_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  grant_found;
  logic [CH_W-1:0]       grant_sel;

  function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] a, input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  assign z_ready = ~pend_q & ~ch_clear;

  // First pending channel at or after rr_ptr, searching circularly
  always_comb begin
    grant_found = 1'b0;
    grant_sel   = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!grant_found && pend_q[ch_inc(rr_ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_sel   = ch_inc(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    x_bank_d      = x_bank_q;
    p_bank_d      = p_bank_q;
    q_bank_d      = q_bank_q;
    r_bank_d      = r_bank_q;
    zbuf_d        = zbuf_q;
    pend_d        = pend_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    discard_d     = discard_q;
    core_x_d      = core_x_q;
    core_p_d      = core_p_q;
    core_z_d      = core_z_q;
    core_q_d      = core_q_q;
    core_r_d      = core_r_q;
    out_valid_d   = 1'b0;
    out_ch_d      = out_ch_q;
    out_x_d       = out_x_q;
    timeout_err_d = 1'b0;

    if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
      q_bank_d[cfg_ch] = cfg_q;
      r_bank_d[cfg_ch] = cfg_r;
    end

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (z_valid[i] && z_ready[i]) begin
        zbuf_d[i] = z_in[i*STATE_BITS +: STATE_BITS];
        pend_d[i] = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          grant_d           = grant_sel;
          core_x_d          = x_bank_q[grant_sel];
          core_p_d          = p_bank_q[grant_sel];
          core_z_d          = zbuf_q[grant_sel];
          core_q_d          = q_bank_q[grant_sel];
          core_r_d          = r_bank_q[grant_sel];
          pend_d[grant_sel] = 1'b0;
          discard_d         = ch_clear[grant_sel];
          state_d           = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d     = '0;
        discard_d = discard_q | ch_clear[grant_q];
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // A clear of the granted channel anywhere in flight turns its result into a no-op
        discard_d = discard_q | ch_clear[grant_q];
        if (core_done) begin
          if (!discard_d) begin
            x_bank_d[grant_q] = core_x_new;
            p_bank_d[grant_q] = core_p_new;
            out_valid_d       = 1'b1;
            out_ch_d          = grant_q;
            out_x_d           = core_x_new;
          end
          state_d = S_WB;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_err_d = 1'b1;
          rr_ptr_d      = ch_inc(grant_q, 1);
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        rr_ptr_d = ch_inc(grant_q, 1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Clears override both core write-back and sample capture
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_clear[i]) begin
        x_bank_d[i] = '0;
        p_bank_d[i] = P_INIT;
        pend_d[i]   = 1'b0;
      end
    end

    core_start_d = (state_d == S_ISSUE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        x_bank_q[i] <= '0;
        p_bank_q[i] <= P_INIT;
        q_bank_q[i] <= '0;
        r_bank_q[i] <= '0;
        zbuf_q[i]   <= '0;
      end
      pend_q        <= '0;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      cnt_q         <= '0;
      discard_q     <= 1'b0;
      core_start_q  <= 1'b0;
      core_x_q      <= '0;
      core_p_q      <= '0;
      core_z_q      <= '0;
      core_q_q      <= '0;
      core_r_q      <= '0;
      out_valid_q   <= 1'b0;
      out_ch_q      <= '0;
      out_x_q       <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_bank_q      <= x_bank_d;
      p_bank_q      <= p_bank_d;
      q_bank_q      <= q_bank_d;
      r_bank_q      <= r_bank_d;
      zbuf_q        <= zbuf_d;
      pend_q        <= pend_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      cnt_q         <= cnt_d;
      discard_q     <= discard_d;
      core_start_q  <= core_start_d;
      core_x_q      <= core_x_d;
      core_p_q      <= core_p_d;
      core_z_q      <= core_z_d;
      core_q_q      <= core_q_d;
      core_r_q      <= core_r_d;
      out_valid_q   <= out_valid_d;
      out_ch_q      <= out_ch_d;
      out_x_q       <= out_x_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign core_start  = core_start_q;
  assign core_x      = core_x_q;
  assign core_p      = core_p_q;
  assign core_z      = core_z_q;
  assign core_q      = core_q_q;
  assign core_r      = core_r_q;
  assign out_valid   = out_valid_q;
  assign out_ch      = out_ch_q;
  assign out_x       = out_x_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_kalman_channel_scheduler.sv
// Scoreboard bench for kalman_channel_scheduler: directed stimulus pushes expected core
// operands and published estimates; monitors pop and compare as the DUT presents them.
module tb_kalman_channel_scheduler;

  localparam logic [63:0] PI = 64'd1 << 30;

  typedef struct {
    logic [15:0] x;
    logic [63:0] p;
    logic [15:0] z;
    logic [63:0] q;
    logic [63:0] r;
  } iss_t;

  typedef struct {
    int          d;
    logic [15:0] x;
    logic [63:0] p;
  } rsp_t;

  typedef struct {
    int          ch;
    logic [15:0] x;
  } out_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  z_valid = '0;
  logic [63:0] z_in = '0;
  logic [3:0]  z_ready;
  logic [3:0]  ch_clear = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [63:0] cfg_q = '0;
  logic [63:0] cfg_r = '0;
  logic        core_start;
  logic [15:0] core_x;
  logic [63:0] core_p;
  logic [15:0] core_z;
  logic [63:0] core_q;
  logic [63:0] core_r;
  logic        core_done = 1'b0;
  logic [15:0] core_x_new = '0;
  logic [63:0] core_p_new = '0;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [15:0] out_x;
  logic        busy;
  logic        timeout_err;

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_to = 0;
  int   inject_req = 0;
  iss_t exp_iss[$];
  rsp_t rsp_q[$];
  out_t exp_out[$];

  kalman_channel_scheduler dut (
    .clk(clk), .reset(reset), .z_valid(z_valid), .z_in(z_in), .z_ready(z_ready),
    .ch_clear(ch_clear), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_q(cfg_q), .cfg_r(cfg_r),
    .core_start(core_start), .core_x(core_x), .core_p(core_p), .core_z(core_z),
    .core_q(core_q), .core_r(core_r), .core_done(core_done), .core_x_new(core_x_new),
    .core_p_new(core_p_new), .out_valid(out_valid), .out_ch(out_ch), .out_x(out_x),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s", name);
  endtask

  task automatic expect_upd(input iss_t i, input rsp_t r, input bit pub, input int ch);
    exp_iss.push_back(i);
    rsp_q.push_back(r);
    if (pub) exp_out.push_back('{ch: ch, x: r.x});
  endtask

  // Core model: answers each core_start after rsp.d cycles (negative: never), plus injected dones
  initial begin
    int   ack = 0;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (inject_req != ack) begin
        ack++;
        core_done = 1'b1; core_x_new = 16'h7FFF; core_p_new = 64'h7;
        @(negedge clk);
        core_done = 1'b0;
      end else if (core_start === 1'b1 && rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        if (r.d >= 0) begin
          repeat (r.d) @(negedge clk);
          core_done = 1'b1; core_x_new = r.x; core_p_new = r.p;
          @(negedge clk);
          core_done = 1'b0;
        end
      end
    end
  end

  // Operand monitor
  initial begin
    iss_t e;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1) begin
        if (exp_iss.size() == 0) fail("unexpected core_start");
        else begin
          e = exp_iss.pop_front();
          check("core_x", 64'(core_x), 64'(e.x));
          check("core_p", core_p, e.p);
          check("core_z", 64'(core_z), 64'(e.z));
          check("core_q", core_q, e.q);
          check("core_r", core_r, e.r);
        end
      end
    end
  end

  // Output monitor
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      if (timeout_err === 1'b1) n_to++;
      if (out_valid === 1'b1) begin
        if (exp_out.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected out_valid: ch %0d x %h", out_ch, out_x);
        end else begin
          e = exp_out.pop_front();
          check("out_ch", 64'(out_ch), 64'(e.ch));
          check("out_x", 64'(out_x), 64'(e.x));
        end
      end
    end
  end

  task automatic cfg(input int ch, input logic [63:0] q, input logic [63:0] r);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_q = q; cfg_r = r;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic put_z(input int ch, input logic [15:0] z);
    int n = 0;
    @(negedge clk);
    z_in[ch*16 +: 16] = z;
    z_valid[ch] = 1'b1;
    while (!z_ready[ch] && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) fail("put_z ready timeout");
    @(negedge clk);
    z_valid[ch] = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (core_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail("core_start timeout");
  endtask

  task automatic wait_quiet();
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < 3000) begin
      @(negedge clk); n++;
      if (!busy && z_ready == 4'hF && z_valid == 4'h0) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) fail("wait_quiet timeout");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset values
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    check("rst_z_ready", 64'(z_ready), 64'hF);
    check("rst_out_x", 64'(out_x), 64'd0);
    check("rst_core_p", core_p, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    cfg(0, 64'h4000_0000, 64'h4000_0000);
    cfg(1, 64'h100, 64'h200);
    cfg(2, 64'h300, 64'h400);
    cfg(3, 64'h500, 64'h600);

    // Single channel with latency checks
    expect_upd('{16'h0, PI, 16'h2000, 64'h4000_0000, 64'h4000_0000}, '{1, 16'h1000, 64'h3000_0000}, 1, 0);
    @(negedge clk);
    z_in[15:0] = 16'h2000; z_valid[0] = 1'b1;
    check("t1_ready", 64'(z_ready[0]), 64'd1);
    @(negedge clk);
    z_valid[0] = 1'b0;
    check("t1_idle_start", 64'(core_start), 64'd0);
    @(negedge clk);
    check("t1_issue_start", 64'(core_start), 64'd1);
    check("t1_issue_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("t1_wait_out", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("t1_latency_out", 64'(out_valid), 64'd1);
    wait_quiet();

    // Lone ch3 update moves rr_ptr back to 0
    expect_upd('{16'h0, PI, 16'h0700, 64'h500, 64'h600}, '{1, 16'h0070, 64'h2000_0000}, 1, 3);
    put_z(3, 16'h0700);
    wait_quiet();

    // All four pending at once
    expect_upd('{16'h1000, 64'h3000_0000, 16'h0111, 64'h4000_0000, 64'h4000_0000}, '{1, 16'h0A00, 64'h2800_0000}, 1, 0);
    expect_upd('{16'h0, PI, 16'h0222, 64'h100, 64'h200}, '{1, 16'h0B00, 64'h2900_0000}, 1, 1);
    expect_upd('{16'h0, PI, 16'h0333, 64'h300, 64'h400}, '{1, 16'h0C00, 64'h2A00_0000}, 1, 2);
    expect_upd('{16'h0070, 64'h2000_0000, 16'h0444, 64'h500, 64'h600}, '{1, 16'h0D00, 64'h2B00_0000}, 1, 3);
    @(negedge clk);
    z_in = {16'h0444, 16'h0333, 16'h0222, 16'h0111}; z_valid = 4'hF;
    @(negedge clk);
    z_valid = 4'h0;
    wait_quiet();

    // ch1 and ch3 pending with rr_ptr=0 -> ch1 first
    expect_upd('{16'h0B00, 64'h2900_0000, 16'h1234, 64'h100, 64'h200}, '{1, 16'h0E00, 64'h2C00_0000}, 1, 1);
    expect_upd('{16'h0D00, 64'h2B00_0000, 16'hC321, 64'h500, 64'h600}, '{1, 16'h0F00, 64'h2D00_0000}, 1, 3);
    @(negedge clk);
    z_in = {16'hC321, 16'h0, 16'h1234, 16'h0}; z_valid = 4'b1010;
    @(negedge clk);
    z_valid = 4'h0;
    wait_quiet();

    // Back-to-back ch2 with a cfg write on the issue edge of the first update
    expect_upd('{16'h0C00, 64'h2A00_0000, 16'h0555, 64'h300, 64'h400}, '{1, 16'h0100, 64'h1000_0000}, 1, 2);
    expect_upd('{16'h0100, 64'h1000_0000, 16'h0666, 64'h700, 64'h800}, '{1, 16'h0200, 64'h0800_0000}, 1, 2);
    @(negedge clk);
    z_in[47:32] = 16'h0555; z_valid[2] = 1'b1;
    @(negedge clk);
    z_in[47:32] = 16'h0666;
    check("t3_ready_pending", 64'(z_ready[2]), 64'd0);
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_q = 64'h700; cfg_r = 64'h800;
    @(negedge clk);
    cfg_we = 1'b0;
    check("t3_issue_start", 64'(core_start), 64'd1);
    check("t3_ready_in_issue", 64'(z_ready[2]), 64'd1);
    @(negedge clk);
    check("t3_second_accepted", 64'(z_ready[2]), 64'd0);
    z_valid[2] = 1'b0;
    wait_quiet();

    // Timeout on ch0, then ch1 serviced
    expect_upd('{16'h0A00, 64'h2800_0000, 16'h0999, 64'h4000_0000, 64'h4000_0000}, '{-1, 16'h0, 64'h0}, 0, 0);
    expect_upd('{16'h0E00, 64'h2C00_0000, 16'h0AAA, 64'h100, 64'h200}, '{1, 16'h0F0F, 64'h2E00_0000}, 1, 1);
    @(negedge clk);
    z_in = {16'h0, 16'h0, 16'h0AAA, 16'h0999}; z_valid = 4'b0011;
    @(negedge clk);
    z_valid = 4'h0;
    wait_start();
    k = 0;
    while (timeout_err !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    check("t4_timeout_wait", 64'(k), 64'd256);
    check("t4_timeout_no_out", 64'(out_valid), 64'd0);
    check("t4_timeout_idle", 64'(busy), 64'd0);
    wait_quiet();

    // ch_clear during ch1 WAIT discards the result
    expect_upd('{16'h0F0F, 64'h2E00_0000, 16'h0123, 64'h100, 64'h200}, '{3, 16'h5555, 64'h5555}, 0, 1);
    put_z(1, 16'h0123);
    wait_start();
    @(negedge clk);
    ch_clear[1] = 1'b1;
    #1;
    check("t5_clear_blocks_ready", 64'(z_ready[1]), 64'd0);
    @(negedge clk);
    ch_clear[1] = 1'b0;
    wait_quiet();
    expect_upd('{16'h0, PI, 16'h0321, 64'h100, 64'h200}, '{1, 16'h0777, 64'h1111_0000}, 1, 1);
    put_z(1, 16'h0321);
    wait_quiet();
    expect_upd('{16'h0A00, 64'h2800_0000, 16'h0BBB, 64'h4000_0000, 64'h4000_0000}, '{1, 16'h0888, 64'h1234_5678}, 1, 0);
    put_z(0, 16'h0BBB);
    wait_quiet();

    // Reset during WAIT, then a late core_done
    expect_upd('{16'h0200, 64'h0800_0000, 16'h0ABC, 64'h700, 64'h800}, '{-1, 16'h0, 64'h0}, 0, 2);
    put_z(2, 16'h0ABC);
    wait_start();
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_reset_busy", 64'(busy), 64'd0);
    check("t6_reset_start", 64'(core_start), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    inject_req++;
    repeat (4) @(negedge clk);
    check("t6_late_done_busy", 64'(busy), 64'd0);
    expect_upd('{16'h0, PI, 16'h0001, 64'h0, 64'h0}, '{1, 16'h0002, 64'h1}, 1, 2);
    expect_upd('{16'h0, PI, 16'h0002, 64'h0, 64'h0}, '{1, 16'h0003, 64'h2}, 1, 3);
    @(negedge clk);
    z_in = {16'h0002, 16'h0001, 16'h0, 16'h0}; z_valid = 4'b1100;
    @(negedge clk);
    z_valid = 4'h0;
    wait_quiet();

    check("end_issue_queue", 64'(exp_iss.size()), 64'd0);
    check("end_out_queue", 64'(exp_out.size()), 64'd0);
    check("end_timeouts", 64'(n_to), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/kalman_channel_scheduler.md
Name: kalman_channel_scheduler

Overview:
- Time-shares one single-update Kalman core across NUM_CH independent sensor channels.
- Holds per-channel state (x, P) and per-channel noise configuration (Q, R).
- Buffers one measurement per channel and arbitrates pending channels round-robin.
- Issues one update at a time to the core, writes the result back, and publishes a tagged estimate.

Parameters:
- NUM_CH, 4, number of channels; must be >= 2.
- STATE_BITS, 16, signed state/measurement width (Q15).
- VAR_BITS, 64, unsigned variance width (Q30).
- P_INIT, 64'd1<<30, P value after reset or clear (1.0 in Q30).
- TIMEOUT_CYC, 255, maximum WAIT cycles before the update is aborted.
- CH_W, $clog2(NUM_CH), channel index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- z_valid  in  NUM_CH  per-channel measurement valid
- z_in  in  NUM_CH*STATE_BITS  packed measurements; channel i is z_in[i*STATE_BITS +: STATE_BITS]
- z_ready  out  NUM_CH  per-channel accept
- ch_clear  in  NUM_CH  per-channel state reset pulse
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  CH_W  configuration target channel
- cfg_q  in  VAR_BITS  process variance Q
- cfg_r  in  VAR_BITS  measurement variance R
- core_start  out  1  one-cycle update request to the core
- core_x  out  STATE_BITS  prior x operand
- core_p  out  VAR_BITS  prior P operand
- core_z  out  STATE_BITS  measurement operand
- core_q  out  VAR_BITS  Q operand
- core_r  out  VAR_BITS  R operand
- core_done  in  1  core result valid, one-cycle pulse
- core_x_new  in  STATE_BITS  updated x from core
- core_p_new  in  VAR_BITS  updated P from core
- out_valid  out  1  estimate published, one-cycle pulse
- out_ch  out  CH_W  channel tag of the published estimate
- out_x  out  STATE_BITS  published estimate
- busy  out  1  FSM not in IDLE
- timeout_err  out  1  one-cycle pulse on an aborted update

Behaviour:
- Reset (async, while reset=1):
  - All outputs 0; z_ready = all ones once pend clears.
  - x bank = 0, P bank = P_INIT, Q/R banks = 0, pend = 0, rr_ptr = 0, FSM = IDLE.
  - Assertion mid-operation abandons the in-flight update; a late core_done after release is ignored (FSM is in IDLE).
- Input buffer:
  - z_ready[i] = !pend[i] && !ch_clear[i] (combinational).
  - On an edge with z_valid[i] && z_ready[i], capture z_in slice into zbuf[i] and set pend[i].
- Config:
  - On cfg_we with cfg_ch < NUM_CH, write Q[cfg_ch] and R[cfg_ch]; out-of-range cfg_ch is ignored.
  - New values apply to updates issued after the write edge.
- Operand registers (core_x/p/z/q/r):
  - Loaded on the IDLE->ISSUE edge.
  - Held stable until the next issue; in-flight updates are unaffected by cfg writes.
- FSM:
  - IDLE: if any pend, grant the first pending channel at or after rr_ptr (circular search), load operands, go to ISSUE.
  - ISSUE (1 cycle): core_start=1, clear pend[grant], reset wait counter, go to WAIT.
  - WAIT: on core_done, write core_x_new/core_p_new into bank[grant] (unless discarded), go to WRITEBACK. If the counter reaches TIMEOUT_CYC without core_done, pulse timeout_err, leave bank unchanged, set rr_ptr = grant+1 mod NUM_CH, go to IDLE.
  - WRITEBACK (1 cycle): out_valid=1, out_ch=grant, out_x=written x; rr_ptr = grant+1 mod NUM_CH; go to IDLE.
  - busy = (state != IDLE).
- Latency: accept at edge E0 -> core_start high in cycle after E1. With core_done in the first WAIT cycle, out_valid is high in the cycle after E3.
- Throughput: one update per 4 cycles minimum. pend[i] clears at the ISSUE edge, so channel i can accept its next sample while its current update is in flight.
- ch_clear[i]:
  - Sets x[i]=0, P[i]=P_INIT, clears pend[i].
  - If i is the in-flight grant, the result is discarded: no bank write, no out_valid. FSM still completes WAIT/timeout normally.
  - Clear takes priority over a bank write from the core on the same edge.
  - Clear takes priority over z_valid[i] on the same edge (sample not accepted, since z_ready[i]=0).
- Simultaneous cfg_we and issue for the same channel on one edge: the issue uses the old Q/R.
- Spurious core_done outside WAIT is ignored.

Test Plan:
- Single channel: cfg ch0 Q=0x4000_0000, R=0x4000_0000; z_valid[0] with z=0x2000; core model done after 1 cycle returns x=0x1000, P=0x3000_0000 -> core_x=0, core_p=0x4000_0000, core_z=0x2000; out_valid with out_ch=0, out_x=0x1000 exactly 3 edges after the accepting edge; bank0 updated.
- All 4 channels pending simultaneously, rr_ptr=0 -> grants in order 0,1,2,3. Then pend on ch1 and ch3 with rr_ptr=0 after ch3 serviced -> ch1 before ch3.
- Back-to-back on ch2: second z_valid held high -> accepted on the ISSUE edge of the first update, not before; both results published in order, the second using the first's x/P as prior.
- Core never asserts done -> timeout_err pulse after 255 WAIT cycles; no out_valid; bank unchanged; next pending channel serviced.
- ch_clear[1] during ch1 WAIT -> no out_valid for ch1; subsequent ch1 issue shows core_x=0, core_p=P_INIT.
- reset asserted in WAIT, deasserted, then late core_done -> no out_valid; all banks at reset values; busy=0.
